polar_decode_stage: RTL and testbench

- Bit-serial hard-decision inverse butterfly stage for the NR polar chain. It is the decoder-side counterpart of the serial encode stages.
- Span d = 2^STAGE. For every 2d-bit group of a frame: out[i] = in[i] XOR in[i+d] and out[i+d] = in[i+d].
- Uses a single-path delay-feedback structure: one d-bit delay line plus a frame counter.
- Output order is preserved, so several instances can be cascaded in the same way as the encode stages.

---
 rtl/polar_decode_stage.sv | 161 ++++++++++++++++
 tb/tb_polar_decode_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_decode_stage.sv
// polar_decode_stage
//   Bit-serial hard-decision inverse butterfly stage with span d = 2**STAGE.
//   Within every 2d-bit group of an N-bit frame:
//     out[i]   = in[i] ^ in[i+d]
//     out[i+d] = in[i+d]
//   Single-path delay-feedback: a d-bit delay line plus an N_LOG2-bit frame
//   counter. Output order equals input order, so stages cascade directly.
//   The last d bits of a frame are still in the delay line once the final
//   input arrives; they are flushed during a d-cycle drain, and readyOut is
//   low for that time.
//
// Parameters
//   N_LOG2 : log2 of the frame length N (must be >= STAGE+1)
//   STAGE  : butterfly span exponent, d = 2**STAGE
//
// Ports
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high reset
//   enb      : clock enable; low freezes all state and outputs
//   dataIn   : serial hard-decision input bit
//   validIn  : dataIn qualifier
//   readyOut : input can be accepted (low while draining)
//   dataOut  : serial decoded bit, registered
//   validOut : dataOut qualifier, registered
//   lastOut  : marks the final output bit of a frame, registered
//
// States
//   ST_RUN   | accepting frame bits; outputs follow accepts
//   ST_DRAIN | flushing the d buffered bits after the last input of a frame

module polar_decode_stage #(
  parameter int N_LOG2 = 10,
  parameter int STAGE  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enb,
  input  logic dataIn,
  input  logic validIn,
  output logic readyOut,
  output logic dataOut,
  output logic validOut,
  output logic lastOut
);

  localparam int D = 1 << STAGE;
  localparam int N = 1 << N_LOG2;

  localparam logic [N_LOG2-1:0] COUNT_LAST = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0] COUNT_D    = N_LOG2'(D);
  localparam logic [STAGE:0]    DCNT_LAST  = (STAGE + 1)'(D - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [N_LOG2-1:0]   count, count_nxt;
  logic [STAGE:0]      dcnt, dcnt_nxt;
  logic                data_nxt, valid_nxt, last_nxt;

  logic [D-1:0]        dly;
  logic [D-1:0]        dly_shift;
  logic                head;
  logic                push_bit;
  logic                shift_en;
  logic                accept;
  logic                phase;

  assign readyOut = (state == ST_RUN);
  assign accept   = enb & validIn & readyOut;
  assign phase    = count[STAGE];
  assign head     = dly[D-1];

  // While draining, zeros are pushed so the line is clean for the next frame.
  assign push_bit = (state == ST_RUN) ? dataIn : 1'b0;
  assign shift_en = accept | (enb & (state == ST_DRAIN));

  generate
    if (D == 1) begin : g_dly_one
      assign dly_shift = push_bit;
    end else begin : g_dly_many
      assign dly_shift = {dly[D-2:0], push_bit};
    end
  endgenerate

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    dcnt_nxt  = dcnt;
    data_nxt  = dataOut;
    valid_nxt = validOut;
    last_nxt  = lastOut;

    if (enb) begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            count_nxt = count + 1'b1;
            // Second half of a group combines with the bit d positions back;
            // first half releases the second half of the previous group as-is.
            data_nxt  = phase ? (head ^ dataIn) : head;
            valid_nxt = (count >= COUNT_D);
            last_nxt  = 1'b0;
            if (count == COUNT_LAST) begin
              state_nxt = ST_DRAIN;
              dcnt_nxt  = '0;
            end
          end else begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
          end
        end

        ST_DRAIN: begin
          data_nxt  = head;
          valid_nxt = 1'b1;
          dcnt_nxt  = dcnt + 1'b1;
          last_nxt  = 1'b0;
          if (dcnt == DCNT_LAST) begin
            last_nxt  = 1'b1;
            state_nxt = ST_RUN;
          end
        end

        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      count    <= '0;
      dcnt     <= '0;
      dataOut  <= 1'b0;
      validOut <= 1'b0;
      lastOut  <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      dcnt     <= dcnt_nxt;
      dataOut  <= data_nxt;
      validOut <= valid_nxt;
      lastOut  <= last_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly <= '0;
    end else if (shift_en) begin
      dly <= dly_shift;
    end
  end

endmodule

// File: tb/tb_polar_decode_stage.sv
module tb_polar_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic s_enb = 1'b1, s_din = 1'b0, s_vin = 1'b0;
  logic s_rdy, s_dout, s_vout, s_last;
  logic b_enb = 1'b1, b_din = 1'b0, b_vin = 1'b0;
  logic b_rdy, b_dout, b_vout, b_last;

  int n_cmp = 0;
  int n_err = 0;

  logic s_q[$];
  logic b_q[$];
  int   s_oidx = 0, b_oidx = 0;
  int   s_nout = 0, b_nout = 0;
  logic s_en_edge = 1'b0, b_en_edge = 1'b0;
  logic s_e, b_e;

  always #5 clk = ~clk;

  polar_decode_stage #(.N_LOG2(3), .STAGE(1)) u_small (
    .clk(clk), .reset(rst), .enb(s_enb), .dataIn(s_din), .validIn(s_vin),
    .readyOut(s_rdy), .dataOut(s_dout), .validOut(s_vout), .lastOut(s_last)
  );

  polar_decode_stage u_big (
    .clk(clk), .reset(rst), .enb(b_enb), .dataIn(b_din), .validIn(b_vin),
    .readyOut(b_rdy), .dataOut(b_dout), .validOut(b_vout), .lastOut(b_last)
  );

  // Remember whether the last edge was an enabled one, so held outputs
  // during enb-low are not counted as new bits.
  always @(posedge clk) begin
    s_en_edge <= s_enb & ~rst;
    b_en_edge <= b_enb & ~rst;
  end

  // Scoreboard for the small instance
  always @(negedge clk) begin
    if (!rst && s_en_edge && s_vout) begin
      s_nout++;
      n_cmp++;
      if (s_q.size() == 0) begin
        n_err++;
        $display("FAIL small_unexpected_out: got dataOut=%0b, required no output", s_dout);
      end else begin
        s_e = s_q.pop_front();
        if (s_dout !== s_e) begin
          n_err++;
          $display("FAIL small_data idx=%0d: got %0b required %0b", s_oidx, s_dout, s_e);
        end
        n_cmp++;
        if (s_last !== 1'(s_oidx == 7)) begin
          n_err++;
          $display("FAIL small_last idx=%0d: got %0b required %0b", s_oidx, s_last, s_oidx == 7);
        end
        s_oidx = (s_oidx + 1) % 8;
      end
    end else if (!rst && s_en_edge && !s_vout) begin
      n_cmp++;
      if (s_last !== 1'b0) begin
        n_err++;
        $display("FAIL small_last_idle: got %0b required 0", s_last);
      end
    end
  end

  // Scoreboard for the full-size instance
  always @(negedge clk) begin
    if (!rst && b_en_edge && b_vout) begin
      b_nout++;
      n_cmp++;
      if (b_q.size() == 0) begin
        n_err++;
        $display("FAIL big_unexpected_out: got dataOut=%0b, required no output", b_dout);
      end else begin
        b_e = b_q.pop_front();
        if (b_dout !== b_e) begin
          n_err++;
          $display("FAIL big_data idx=%0d: got %0b required %0b", b_oidx, b_dout, b_e);
        end
        if (b_oidx == 1023 || b_last) begin
          n_cmp++;
          if (b_last !== 1'(b_oidx == 1023)) begin
            n_err++;
            $display("FAIL big_last idx=%0d: got %0b required %0b", b_oidx, b_last, b_oidx == 1023);
          end
        end
        b_oidx = (b_oidx + 1) % 1024;
      end
    end
  end

  // Reference inverse butterfly for an 8-bit frame with d = 2
  function automatic logic [7:0] model8(input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int g = 0; g < 8; g += 4) begin
      for (int i = 0; i < 2; i++) begin
        y[g+i]   = x[g+i] ^ x[g+i+2];
        y[g+i+2] = x[g+i+2];
      end
    end
    return y;
  endfunction

  task automatic idle_small(input int n);
    s_vin = 1'b0;
    s_din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_small_empty(input string name);
    n_cmp++;
    if (s_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: got %0d pending outputs required 0", name, s_q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s_dout, s_vout, s_last, s_rdy} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_small: got dout/vout/last/rdy=%b required 0001", {s_dout, s_vout, s_last, s_rdy});
    end
    n_cmp++;
    if ({b_dout, b_vout, b_last, b_rdy} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_big: got dout/vout/last/rdy=%b required 0001", {b_dout, b_vout, b_last, b_rdy});
    end
    rst = 1'b0;
    s_oidx = 0;
    b_oidx = 0;
    idle_small(2);
  endtask

  task automatic test_basic_frame;
    logic [7:0] pat;
    logic [7:0] expo;
    int low;
    pat  = 8'hED;   // 1,0,1,1,0,1,1,1 (index 0 in LSB)
    expo = 8'hDE;   // 0,1,1,1,1,0,1,1
    for (int i = 0; i < 8; i++) s_q.push_back(expo[i]);
    for (int i = 0; i < 8; i++) begin
      s_din = pat[i];
      s_vin = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (s_vout !== 1'(i >= 2)) begin
        n_err++;
        $display("FAIL basic_valid_timing in=%0d: got %0b required %0b", i, s_vout, i >= 2);
      end
    end
    s_vin = 1'b0;
    s_din = 1'b0;
    low = 0;
    for (int c = 0; c < 5; c++) begin
      if (s_rdy === 1'b0) low++;
      @(negedge clk);
    end
    n_cmp++;
    if (low != 2) begin
      n_err++;
      $display("FAIL basic_ready_low: got %0d cycles required 2", low);
    end
    check_small_empty("basic");
  endtask

  task automatic test_gapped;
    logic [7:0] pat;
    logic [7:0] expo;
    pat  = 8'hED;
    expo = model8(pat);
    for (int i = 0; i < 8; i++) s_q.push_back(expo[i]);
    for (int i = 0; i < 8; i++) begin
      s_din = pat[i];
      s_vin = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (s_vout !== 1'(i >= 2)) begin
        n_err++;
        $display("FAIL gapped_valid in=%0d: got %0b required %0b", i, s_vout, i >= 2);
      end
      if (i < 7) begin
        s_vin = 1'b0;
        s_din = ~pat[i];
        @(negedge clk);
        n_cmp++;
        if (s_vout !== 1'b0) begin
          n_err++;
          $display("FAIL gapped_idle in=%0d: got validOut=%0b required 0", i, s_vout);
        end
      end
    end
    idle_small(4);
    check_small_empty("gapped");
  endtask

  task automatic test_backpressure;
    logic [7:0] pat;
    logic [7:0] expo;
    logic [7:0] ones_exp;
    int accepted, dropped, cyc;
    pat      = 8'h5A;
    expo     = model8(pat);
    ones_exp = 8'hCC;   // 0,0,1,1,0,0,1,1
    for (int i = 0; i < 8; i++) s_q.push_back(expo[i]);
    for (int i = 0; i < 8; i++) s_q.push_back(ones_exp[i]);
    for (int i = 0; i < 8; i++) begin
      s_din = pat[i];
      s_vin = 1'b1;
      @(negedge clk);
    end
    s_din = 1'b1;
    s_vin = 1'b1;
    accepted = 0;
    dropped  = 0;
    cyc      = 0;
    while (accepted < 8 && cyc < 30) begin
      if (s_rdy) accepted++;
      else dropped++;
      @(negedge clk);
      cyc++;
    end
    idle_small(5);
    n_cmp++;
    if (accepted != 8) begin
      n_err++;
      $display("FAIL bp_accepts: got %0d required 8 within 30 cycles", accepted);
    end
    n_cmp++;
    if (dropped != 2) begin
      n_err++;
      $display("FAIL bp_dropped: got %0d required 2", dropped);
    end
    check_small_empty("bp");
  endtask

  task automatic test_enb_freeze;
    logic [7:0] pat;
    logic [7:0] expo;
    logic [3:0] snap;
    int start_out;
    pat  = 8'h96;
    expo = model8(pat);
    for (int i = 0; i < 8; i++) s_q.push_back(expo[i]);
    start_out = s_nout;
    for (int i = 0; i < 8; i++) begin
      s_din = pat[i];
      s_vin = 1'b1;
      if (i == 4) begin
        snap  = {s_dout, s_vout, s_last, s_rdy};
        s_enb = 1'b0;
        repeat (3) begin
          @(negedge clk);
          n_cmp++;
          if ({s_dout, s_vout, s_last, s_rdy} !== snap) begin
            n_err++;
            $display("FAIL freeze_frame: got %b required %b", {s_dout, s_vout, s_last, s_rdy}, snap);
          end
        end
        s_enb = 1'b1;
      end
      @(negedge clk);
    end
    s_vin = 1'b0;
    @(negedge clk);
    snap  = {s_dout, s_vout, s_last, s_rdy};
    s_enb = 1'b0;
    s_vin = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({s_dout, s_vout, s_last, s_rdy} !== snap) begin
        n_err++;
        $display("FAIL freeze_drain: got %b required %b", {s_dout, s_vout, s_last, s_rdy}, snap);
      end
    end
    s_enb = 1'b1;
    idle_small(4);
    n_cmp++;
    if (s_nout - start_out != 8) begin
      n_err++;
      $display("FAIL freeze_count: got %0d outputs required 8", s_nout - start_out);
    end
    check_small_empty("freeze");
  endtask

  task automatic test_async_reset;
    logic [7:0] pat;
    logic [7:0] expo;
    pat  = 8'h3C;
    expo = model8(pat);
    for (int i = 0; i < 4; i++) s_q.push_back(expo[i]);
    for (int i = 0; i < 6; i++) begin
      s_din = pat[i];
      s_vin = 1'b1;
      @(negedge clk);
    end
    s_vin = 1'b0;
    #2;
    check_small_empty("pre_reset");
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({s_dout, s_vout, s_last, s_rdy} !== 4'b0001) begin
      n_err++;
      $display("FAIL async_reset: got dout/vout/last/rdy=%b required 0001", {s_dout, s_vout, s_last, s_rdy});
    end
    rst = 1'b0;
    s_oidx = 0;
    idle_small(4);
    pat  = 8'($urandom);
    expo = model8(pat);
    for (int i = 0; i < 8; i++) s_q.push_back(expo[i]);
    for (int i = 0; i < 8; i++) begin
      s_din = pat[i];
      s_vin = 1'b1;
      @(negedge clk);
    end
    idle_small(4);
    check_small_empty("post_reset");
  endtask

  task automatic test_round_trip;
    logic orig[1024];
    logic enc[1024];
    for (int i = 0; i < 1024; i++) orig[i] = 1'($urandom_range(0, 1));
    for (int g = 0; g < 1024; g += 512) begin
      for (int i = 0; i < 256; i++) begin
        enc[g+i]     = orig[g+i] ^ orig[g+i+256];
        enc[g+i+256] = orig[g+i+256];
      end
    end
    for (int i = 0; i < 1024; i++) b_q.push_back(orig[i]);
    for (int i = 0; i < 1024; i++) begin
      b_din = enc[i];
      b_vin = 1'b1;
      @(negedge clk);
      if (i == 255 || i == 256) begin
        n_cmp++;
        if (b_vout !== 1'(i == 256)) begin
          n_err++;
          $display("FAIL rt_latency in=%0d: got validOut=%0b required %0b", i, b_vout, i == 256);
        end
      end
    end
    b_vin = 1'b0;
    repeat (262) @(negedge clk);
    n_cmp++;
    if (b_q.size() != 0 || b_nout != 1024) begin
      n_err++;
      $display("FAIL rt_count: got %0d outputs (%0d pending) required 1024", b_nout, b_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gapped();
    test_backpressure();
    test_enb_freeze();
    test_async_reset();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
